// File: rtl/fpga_io_pkg.sv
// ============================================================
// fpga_io_pkg : shared widths and defaults for board input conditioning
// Rev 1.0
// ============================================================
`default_nettype none

package fpga_io_pkg;

  localparam int IO_WIDTH         = 10;
  localparam int DEBOUNCE_DEFAULT = 16;
  // Bits 9:8 are the slide switches, wired active-low on the board
  localparam logic [IO_WIDTH-1:0] SW_INVERT_MASK = 10'b11_0000_0000;

endpackage

`default_nettype wire

// File: rtl/input_debouncer_if.sv
// ============================================================
// input_debouncer_if : raw pin levels in, conditioned levels/pulses out
// Rev 1.0
// ============================================================
`default_nettype none

interface input_debouncer_if
  import fpga_io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH
);

  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clean_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (
    output raw_in,
    input  clean_out,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  raw_in,
    output clean_out,
    output rise_pulse,
    output fall_pulse
  );

endinterface

`default_nettype wire

// File: rtl/debounce_bit.sv
// ============================================================
// debounce_bit : 2-flop synchroniser, qualification counter, edge pulses
// Rev 1.0
// ============================================================
`default_nettype none

module debounce_bit
  import fpga_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic din,
  output logic      clean,
  output logic      rise,
  output logic      fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             done;

  // New level has now been seen for DEBOUNCE_CYCLES consecutive edges
  assign done = (s2 != clean) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= done & s2;
      fall <= done & ~s2;
      if (s2 == clean) begin
        cnt <= '0;
      end else if (done) begin
        clean <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/input_debouncer.sv
// ============================================================
// input_debouncer : polarity fix plus per-bit sync/debounce of board pins
// Rev 1.0
// ============================================================
`default_nettype none

module input_debouncer
  import fpga_io_pkg::*;
#(
  parameter int               WIDTH           = IO_WIDTH,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic [WIDTH-1:0] INVERT_MASK     = WIDTH'(SW_INVERT_MASK)
) (
  input wire logic          clk,
  input wire logic          rst,
  input_debouncer_if.slave  bus
);

  logic [WIDTH-1:0] pol;

  assign pol = bus.raw_in ^ INVERT_MASK;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk   (clk),
      .rst   (rst),
      .din   (pol[i]),
      .clean (bus.clean_out[i]),
      .rise  (bus.rise_pulse[i]),
      .fall  (bus.fall_pulse[i])
    );
  end

endmodule

`default_nettype wire

// File: doc/input_debouncer.md
# input_debouncer

Board-side input conditioner sitting between the FPGA top-level pins (header inputs and slide switches) and the ui_in/uio_in ports of the tt_um design. It applies a per-bit polarity fix, synchronises each asynchronous pin into the clk domain with two flops, and debounces each bit with a per-bit counter. It outputs clean levels plus single-cycle rising/falling-edge pulses, so the user design never sees metastable or bouncing inputs.

## Interface

Parameters:
- WIDTH, 10: number of conditioned inputs (8 header pins + 2 switches).
- DEBOUNCE_CYCLES, 16: consecutive synchronised cycles a new level must hold before clean_out follows; legal range ≥ 1.
- INVERT_MASK, 10'b11_0000_0000: bit set = input is active-low and is inverted before synchronisation.

Ports:
- clk  input  1  system clock; one clock domain only.
- rst  input  1  reset, synchronous, active-high.
- raw_in  input  WIDTH  asynchronous pin levels.
- clean_out  output  WIDTH  debounced, polarity-corrected levels.
- rise_pulse  output  WIDTH  one-cycle pulse per bit on clean 0→1.
- fall_pulse  output  WIDTH  one-cycle pulse per bit on clean 1→0.

## Operation

- Polarity: pol = raw_in ^ INVERT_MASK, combinational, before the first flop.
- Sync: s1 <= pol; s2 <= s1. Both are reset to 0.
- Per-bit counter, width CNT_W = $clog2(DEBOUNCE_CYCLES), minimum 1. Counter, clean_out and the pulse outputs are all reset to 0.
- Each edge, per bit:
  - s2 == clean: counter <= 0 (any bounce back restarts qualification).
  - s2 != clean and counter == DEBOUNCE_CYCLES-1: clean <= s2; counter <= 0.
  - Otherwise: counter <= counter+1.
- Counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- rise_pulse and fall_pulse are registered. A pulse is high exactly during the cycle in which clean_out first shows its new value, and low otherwise. rise and fall are never high together on one bit.
- Bits are fully independent; simultaneous changes on several bits each qualify separately.
- Reset asserted mid-qualification: on the next edge all state and outputs go to 0 and no pulse is emitted. If pol is 1 after reset, a rise follows after the normal latency.
- DEBOUNCE_CYCLES == 1: clean follows s2 one edge later, so the block is sync-only.

## Timing

- Let edge k be the first edge at which s1 captures a new stable pol level.
- s2 holds the new level after edge k+1.
- clean_out and the matching pulse update at edge k+DEBOUNCE_CYCLES+1, and the pulse deasserts at the following edge.
- Worst-case pin-to-clean latency is DEBOUNCE_CYCLES+2 cycles, counting the asynchronous sampling cycle.
- No combinational path from raw_in to any output.
- Outputs reset to 0 one edge after rst is sampled high.

## Structure

- Package fpga_io_pkg holds:
  - IO_WIDTH = 10;
  - DEBOUNCE_DEFAULT = 16;
  - SW_INVERT_MASK = 10'b11_0000_0000, since the switches are active-low on the board.
- Sub-module debounce_bit, with parameter DEBOUNCE_CYCLES, contains the 2-flop sync, counter, clean flop and pulse flops for one bit.
- input_debouncer does the polarity XOR and instantiates WIDTH copies of debounce_bit via generate.
- The FPGA top wires clean_out[7:0] to ui_in and clean_out[9:8] to uio_in[1:0].

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

- Reset: hold rst high with raw_in=10'h3FF for 3 cycles. Required: clean_out=0, rise_pulse=0, fall_pulse=0 each cycle. Then release rst. Required: clean_out=10'h0FF and rise_pulse[7:0]=8'hFF for exactly one cycle, 5 edges after the first edge at which rst is sampled low; bits 9:8 stay 0 because they are inverted.
- Clean step: raw_in[0] goes 0→1 just before edge k. Required: clean_out[0]=1 after edge k+5, rise_pulse[0] high for only the cycle between edges k+5 and k+6, no fall_pulse.
- Bounce: raw_in[3] toggles 1,0,1,0 on successive edges, then holds 1. Required: clean_out[3] stays 0 until 5 edges after the last 0→1 transition, then one rise_pulse[3].
- Short glitch: raw_in[5] goes high for 3 cycles only. Required: clean_out[5] and rise_pulse[5] stay 0 throughout.
- Active-low switch: raw_in[8] goes 1→0. Required: clean_out[8] 0→1 after 5 edges with rise_pulse[8]; raw_in[8] returning 1 gives fall_pulse[8] after 5 edges.
- Reset mid-qualification: raw_in[2] goes high, and rst is pulsed for 1 cycle at edge k+3, then rst is low with raw_in[2] still high. Required: no pulse before reset; clean_out[2] rises 5 edges after reset is released, with a single rise_pulse[2].
